// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous bit. Both stages reset to INIT_VAL.
module sync_2ff #(
    parameter logic INIT_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic s1_q;
    logic s2_q;

    // No logic between the stages, so the second flop only ever sees one flop's output.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q <= INIT_VAL;
            s2_q <= INIT_VAL;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;

endmodule

// File: rtl/debounce_edge_det.sv
// Synchronise and debounce a bouncy level. Emit registered one-cycle rise and fall pulses
// when the filtered level changes.
module debounce_edge_det #(
    parameter int unsigned STABLE_CNT = 8,
    parameter logic        INIT_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    input  logic sample_tick,
    output logic dout,
    output logic rise,
    output logic fall,
    output logic busy
);

    localparam int unsigned CW = (STABLE_CNT > 1) ? $clog2(STABLE_CNT) : 1;
    localparam logic [CW-1:0] TERM = CW'(STABLE_CNT - 1);

    logic          s2;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          dout_q, dout_d;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;
    logic          busy_q, busy_d;

    sync_2ff #(.INIT_VAL(INIT_VAL)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (din),
        .q_o   (s2)
    );

    // A match clears the count even without a tick, so any bounce restarts qualification.
    always_comb begin
        cnt_d  = cnt_q;
        dout_d = dout_q;
        rise_d = 1'b0;
        fall_d = 1'b0;
        if (s2 == dout_q) begin
            cnt_d = '0;
        end else if (sample_tick) begin
            if (cnt_q == TERM) begin
                dout_d = s2;
                cnt_d  = '0;
                rise_d = s2;
                fall_d = ~s2;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
        busy_d = (cnt_d != '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            dout_q <= INIT_VAL;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            dout_q <= dout_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            busy_q <= busy_d;
        end
    end

    assign dout = dout_q;
    assign rise = rise_q;
    assign fall = fall_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_debounce_edge_det.sv
// Scoreboarded bench for debounce_edge_det. Two instances are used: one with
// STABLE_CNT=8 and one with STABLE_CNT=1.
module tb_debounce_edge_det;

    typedef struct {
        int unsigned cyc;
        bit          is_rise;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n;
    logic din_a, tick_a, din_b, tick_b;
    logic dout_a, rise_a, fall_a, busy_a;
    logic dout_b, rise_b, fall_b, busy_b;

    int unsigned cyc = 0;
    int          n_tests = 0;
    int          n_fail  = 0;
    bit          tick_mode = 1'b0;
    ev_t         qa[$];
    ev_t         qb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    debounce_edge_det #(.STABLE_CNT(8), .INIT_VAL(1'b0)) dut_a (
        .clk(clk), .rst_n(rst_n), .din(din_a), .sample_tick(tick_a),
        .dout(dout_a), .rise(rise_a), .fall(fall_a), .busy(busy_a)
    );

    debounce_edge_det #(.STABLE_CNT(1), .INIT_VAL(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .din(din_b), .sample_tick(tick_b),
        .dout(dout_b), .rise(rise_b), .fall(fall_b), .busy(busy_b)
    );

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (tick_mode) tick_a = ((cyc + 1) % 4 == 0);
        end
    endtask

    task automatic chk(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitors: every pulse must match the oldest expected event in time and direction.
    always @(negedge clk) begin
        if (rise_a === 1'b1 || fall_a === 1'b1) begin
            n_tests++;
            if (qa.size() == 0) begin
                n_fail++;
                $display("FAIL a_unexpected_pulse: rise=%b fall=%b at cycle %0d, none expected", rise_a, fall_a, cyc);
            end else begin
                ev_t e;
                e = qa.pop_front();
                if (e.cyc != cyc || rise_a !== e.is_rise || fall_a !== !e.is_rise) begin
                    n_fail++;
                    $display("FAIL a_pulse: rise=%b fall=%b at cycle %0d, expected rise=%b at cycle %0d",
                             rise_a, fall_a, cyc, e.is_rise, e.cyc);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rise_b === 1'b1 || fall_b === 1'b1) begin
            n_tests++;
            if (qb.size() == 0) begin
                n_fail++;
                $display("FAIL b_unexpected_pulse: rise=%b fall=%b at cycle %0d, none expected", rise_b, fall_b, cyc);
            end else begin
                ev_t e;
                e = qb.pop_front();
                if (e.cyc != cyc || rise_b !== e.is_rise || fall_b !== !e.is_rise) begin
                    n_fail++;
                    $display("FAIL b_pulse: rise=%b fall=%b at cycle %0d, expected rise=%b at cycle %0d",
                             rise_b, fall_b, cyc, e.is_rise, e.cyc);
                end
            end
        end
    end

    initial begin
        int unsigned k, r, e;
        rst_n = 1'b0; din_a = 1'b1; tick_a = 1'b1; din_b = 1'b0; tick_b = 1'b1;

        // 1: reset with din high, then a rise 10 edges after release
        step(1);
        for (int i = 0; i < 3; i++) begin
            chk("rst_dout", dout_a, 1'b0); chk("rst_rise", rise_a, 1'b0);
            chk("rst_fall", fall_a, 1'b0); chk("rst_busy", busy_a, 1'b0);
            chk("rst_dout_b", dout_b, 1'b0);
            step(1);
        end
        k = cyc; rst_n = 1'b1;
        qa.push_back('{k + 10, 1'b1});
        step(9);
        chk("rel_dout_before", dout_a, 1'b0);
        step(1);
        chk("rel_dout_after", dout_a, 1'b1);
        step(4);

        // 2: clean fall, busy for exactly 7 cycles beforehand
        k = cyc; din_a = 1'b0;
        qa.push_back('{k + 10, 1'b0});
        step(2);
        chk("fall_busy_pre", busy_a, 1'b0);
        for (int i = 0; i < 7; i++) begin
            step(1);
            chk("fall_busy", busy_a, 1'b1);
            chk("fall_dout_hold", dout_a, 1'b1);
        end
        step(1);
        chk("fall_dout", dout_a, 1'b0);
        chk("fall_busy_end", busy_a, 1'b0);
        step(5);

        // 3: bounce -- only the final 0->1 qualifies
        k = cyc; din_a = 1'b1;
        step(5); din_a = 1'b0;
        step(1); din_a = 1'b1;
        qa.push_back('{k + 16, 1'b1});
        step(9);
        chk("bounce_dout_hold", dout_a, 1'b0);
        step(1);
        chk("bounce_dout", dout_a, 1'b1);
        step(4);

        // 4: tick on every 4th edge; update lands on the 8th tick after s2 changes
        tick_mode = 1'b1; tick_a = ((cyc + 1) % 4 == 0);
        step(4);
        k = cyc; din_a = 1'b0;
        e = k + 3;
        while (e % 4 != 0) e++;
        e += 28;
        qa.push_back('{e, 1'b0});
        while (cyc < e - 1) step(1);
        chk("tick_dout_hold", dout_a, 1'b1);
        chk("tick_busy", busy_a, 1'b1);
        step(1);
        chk("tick_dout", dout_a, 1'b0);
        tick_mode = 1'b0; tick_a = 1'b1;
        step(4);

        // 5: reset mid-qualification discards the partial count
        k = cyc; din_a = 1'b1;
        step(7);
        chk("mid_busy", busy_a, 1'b1);
        rst_n = 1'b0;
        step(1);
        chk("mid_rst_dout", dout_a, 1'b0);
        chk("mid_rst_busy", busy_a, 1'b0);
        rst_n = 1'b1; r = cyc;
        qa.push_back('{r + 10, 1'b1});
        step(3);
        chk("mid_rel_busy", busy_a, 1'b1);
        step(6);
        chk("mid_rel_dout_hold", dout_a, 1'b0);
        step(1);
        chk("mid_rel_dout", dout_a, 1'b1);
        step(3);

        // 6: STABLE_CNT=1 -- update on edge 3, no busy; toggling input
        k = cyc; din_b = 1'b1;
        qb.push_back('{k + 3, 1'b1});
        step(1); chk("b_busy1", busy_b, 1'b0);
        step(1); chk("b_busy2", busy_b, 1'b0);
        step(1); chk("b_dout", dout_b, 1'b1); chk("b_busy3", busy_b, 1'b0);
        step(2);
        for (int i = 0; i < 8; i++) begin
            k = cyc;
            din_b = (i % 2 == 1);
            din_a = (i % 2 == 1);
            qb.push_back('{k + 3, (i % 2 == 1)});
            step(1);
            chk("b_toggle_busy", busy_b, 1'b0);
        end
        step(12);
        chk("a_toggle_dout", dout_a, 1'b1);
        chk("b_final_dout", dout_b, 1'b1);

        n_tests++;
        if (qa.size() != 0 || qb.size() != 0) begin
            n_fail++;
            $display("FAIL missing_pulses: %0d/%0d expected pulses never seen, required 0/0", qa.size(), qb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/debounce_edge_det.md
Name: debounce_edge_det

Overview:
- Downstream consumer of a latch output, or of any asynchronous or bouncy single-bit level such as a D-latch q, switch or strobe.
- Synchronises the bit into the clk domain and filters it so the output changes only after the input has been stable for a set number of sample ticks.
- Emits one-cycle rise and fall pulses for downstream counters and FSMs.

Parameters:
- STABLE_CNT, 8, number of consecutive mismatching sample ticks required before dout changes; legal range 1..65535.
- INIT_VAL, 1'b0, reset value of the synchroniser flops and dout.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on the rising clk edge.
- din  input  1  raw asynchronous level to filter.
- sample_tick  input  1  qualifies counting; tie to 1 to count every clk cycle.
- dout  output  1  debounced level, registered.
- rise  output  1  one-cycle pulse when dout goes 0->1.
- fall  output  1  one-cycle pulse when dout goes 1->0.
- busy  output  1  high while a change is being qualified (cnt != 0).

Behaviour:
- Interface: one clock, clk; reset rst_n is synchronous and active-low. There is no asynchronous reset path.
- Reset (rst_n==0 at a rising edge):
  - s1, s2 and dout load INIT_VAL.
  - cnt loads 0; rise, fall and busy load 0.
  - Reset has priority over every other event, including mid-qualification: any partial count is discarded.
- Synchroniser: s1 <= din; s2 <= s1. No logic sits between s1 and s2.
- Counter width CW = max(1, clog2(STABLE_CNT)), held as a localparam.
- Qualification, evaluated every cycle:
  - s2 == dout: cnt <= 0, regardless of sample_tick. Any bounce back restarts qualification.
  - s2 != dout, sample_tick == 0: cnt holds.
  - s2 != dout, sample_tick == 1, cnt == STABLE_CNT-1: dout <= s2 and cnt <= 0. rise <= s2 or fall <= ~s2 for that single cycle.
  - s2 != dout, sample_tick == 1, otherwise: cnt <= cnt + 1.
- Pulse outputs:
  - rise and fall are registered and default to 0 every cycle unless set by the update above.
  - They are never high together, and never high on the cycle after reset release.
- busy is registered and equals (next cnt != 0).
- Latency with sample_tick == 1: dout changes on rising edge number STABLE_CNT+2. Edge 1 is the first edge that captures the new din into s1.
- STABLE_CNT == 1: an update occurs on the first mismatching tick and busy never asserts.
- Counter never wraps; the terminal compare guarantees cnt <= STABLE_CNT-1.
- din toggling every cycle: dout never changes and cnt repeatedly clears.

Decomposition:
- No shared package is needed. CW is a local localparam; INIT_VAL and STABLE_CNT are module parameters only.
- One sub-module is natural: sync_2ff, the two-flop synchroniser with rst_n and INIT_VAL. It is reused by other CDC inputs in the codebase.
- Counter, compare and pulse logic stay in debounce_edge_det.

Test Plan:
1. Reset with INIT_VAL=0 and din=1 held during reset -> dout=0, rise=0, fall=0, busy=0 for every cycle rst_n=0. Release -> rise pulses exactly once, on edge 10 after release (STABLE_CNT=8, tick=1).
2. STABLE_CNT=8, tick=1, clean din 0->1 -> dout=1 exactly 10 edges later, rise high for 1 cycle, busy high for 7 cycles beforehand. Later 1->0 -> fall pulse, same timing.
3. Bounce: din=1 for 5 cycles, 0 for 1, then 1 steady -> no update from the first burst. dout rises 10 edges after the final 0->1, and only one rise pulse occurs.
4. sample_tick asserted every 4th cycle, din 0->1 -> dout updates on the 8th tick after s2 changes. cnt holds between ticks.
5. rst_n asserted when cnt=5 mid-qualification, din still 1 -> cnt=0 and dout=INIT_VAL. After release, a full 10-edge qualification is required again.
6. STABLE_CNT=1 instance, din 0->1 -> dout=1 on edge 3, busy stays 0. din toggling every cycle -> dout follows s2 with a 1-cycle lag, and rise/fall alternate one at a time.
